// File: rtl/unified_mem_arbiter_if.sv
// Requester and RAM-side signal bundle for unified_mem_arbiter.
// The arbiter uses the slave modport; the IF/MEM stages and the RAM macro drive the master side.
interface unified_mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt;
  logic          if_valid;
  logic [DW-1:0] if_rdata;

  logic          mem_req;
  logic          mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_gnt;
  logic          mem_valid;
  logic [DW-1:0] mem_rdata;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-3:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata;

  logic          stall_if;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
    output if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_be, mem_addr, mem_wdata, ram_rdata,
    input  if_gnt, if_valid, if_rdata, mem_gnt, mem_valid, mem_rdata,
           ram_en, ram_we, ram_addr, ram_wdata, stall_if
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one synchronous-read RAM between instruction fetch and data memory.
// MEM has priority; a burst counter forces an IF grant after MAX_DATA_BURST data wins.
module unified_mem_arbiter #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int MAX_DATA_BURST = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    OWN_NONE,
    OWN_IF,
    OWN_MEM_RD,
    OWN_MEM_WR
  } owner_e;

  owner_e        owner_q, owner_d;
  logic [2:0]    wait_cnt_q, wait_cnt_d;
  logic [DW-1:0] if_rdata_q, mem_rdata_q;

  logic if_win;
  logic if_gnt_c;
  logic mem_gnt_c;

  // Byte offsets are meaningless to a word-wide RAM.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{bus.if_addr[1:0], bus.mem_addr[1:0]};

  assign if_win    = bus.if_req && (!bus.mem_req || (wait_cnt_q == 3'(MAX_DATA_BURST)));
  assign if_gnt_c  = !rst && if_win;
  assign mem_gnt_c = !rst && bus.mem_req && !if_win;

  assign bus.if_gnt    = if_gnt_c;
  assign bus.mem_gnt   = mem_gnt_c;
  assign bus.stall_if  = bus.if_req && !if_gnt_c;
  assign bus.ram_en    = if_gnt_c || mem_gnt_c;
  assign bus.ram_we    = (mem_gnt_c && bus.mem_we) ? bus.mem_be : '0;
  assign bus.ram_addr  = mem_gnt_c ? bus.mem_addr[AW-1:2] : bus.if_addr[AW-1:2];
  assign bus.ram_wdata = bus.mem_wdata;

  always_comb begin
    owner_d    = OWN_NONE;
    wait_cnt_d = wait_cnt_q;
    if (if_gnt_c) begin
      owner_d = OWN_IF;
    end else if (mem_gnt_c) begin
      owner_d = bus.mem_we ? OWN_MEM_WR : OWN_MEM_RD;
    end
    if (!bus.if_req || if_gnt_c) begin
      wait_cnt_d = '0;
    end else if (mem_gnt_c) begin
      wait_cnt_d = wait_cnt_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q     <= OWN_NONE;
      wait_cnt_q  <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      owner_q    <= owner_d;
      wait_cnt_q <= wait_cnt_d;
      if (owner_q == OWN_IF) begin
        if_rdata_q <= bus.ram_rdata;
      end
      if (owner_q == OWN_MEM_RD) begin
        mem_rdata_q <= bus.ram_rdata;
      end
    end
  end

  // The RAM word arrives in the response cycle, so it is forwarded then and held afterwards.
  assign bus.if_valid  = (owner_q == OWN_IF);
  assign bus.mem_valid = (owner_q == OWN_MEM_RD) || (owner_q == OWN_MEM_WR);
  assign bus.if_rdata  = (owner_q == OWN_IF)     ? bus.ram_rdata : if_rdata_q;
  assign bus.mem_rdata = (owner_q == OWN_MEM_RD) ? bus.ram_rdata : mem_rdata_q;

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter with a behavioural synchronous RAM.
// RAM word k resets to 32'hC0DE_0000 + k.
module tb_unified_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   asserts = 0;
  int   fails   = 0;

  unified_mem_arbiter_if #(.AW(32), .DW(32)) bus ();

  unified_mem_arbiter #(.AW(32), .DW(32), .MAX_DATA_BURST(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  logic [31:0] ram_q [256];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 256; i++) ram_q[i] <= 32'hC0DE_0000 + 32'(i);
    end else if (bus.ram_en) begin
      if (bus.ram_we == 4'b0000) begin
        bus.ram_rdata <= ram_q[bus.ram_addr[7:0]];
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.ram_we[b]) ram_q[bus.ram_addr[7:0]][8*b +: 8] <= bus.ram_wdata[8*b +: 8];
      end
    end
  end

  task automatic idle();
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_be    = 4'b0000;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
  endtask

  task automatic test_reset();
    bus.if_req = 1'b1; bus.if_addr = 32'h10;
    bus.mem_req = 1'b1; bus.mem_addr = 32'h100;
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    asserts++; if (bus.if_gnt !== 1'b0) begin fails++; $display("FAIL rst_if_gnt: got %0b want 0", bus.if_gnt); end
    asserts++; if (bus.mem_gnt !== 1'b0) begin fails++; $display("FAIL rst_mem_gnt: got %0b want 0", bus.mem_gnt); end
    asserts++; if (bus.ram_en !== 1'b0) begin fails++; $display("FAIL rst_ram_en: got %0b want 0", bus.ram_en); end
    asserts++; if (bus.ram_we !== 4'b0000) begin fails++; $display("FAIL rst_ram_we: got %b want 0000", bus.ram_we); end
    asserts++; if (bus.if_valid !== 1'b0 || bus.mem_valid !== 1'b0) begin fails++; $display("FAIL rst_valid: got if=%0b mem=%0b want 0 0", bus.if_valid, bus.mem_valid); end
    asserts++; if (bus.if_rdata !== 32'h0 || bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL rst_rdata: got if=%h mem=%h want 0 0", bus.if_rdata, bus.mem_rdata); end
    @(negedge clk);
    rst = 1'b0;
    idle();
  endtask

  task automatic test_single_fetch();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h0000_0010;
    #1;
    asserts++; if (bus.if_gnt !== 1'b1 || bus.ram_en !== 1'b1) begin fails++; $display("FAIL fetch_gnt: got gnt=%0b en=%0b want 1 1", bus.if_gnt, bus.ram_en); end
    asserts++; if (bus.ram_addr !== 30'h4) begin fails++; $display("FAIL fetch_addr: got %h want 4", bus.ram_addr); end
    asserts++; if (bus.stall_if !== 1'b0) begin fails++; $display("FAIL fetch_stall: got %0b want 0", bus.stall_if); end
    @(posedge clk); #1;
    asserts++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hC0DE_0004) begin fails++; $display("FAIL fetch_resp: got v=%0b d=%h want 1 c0de0004", bus.if_valid, bus.if_rdata); end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    asserts++; if (bus.if_valid !== 1'b0 || bus.if_rdata !== 32'hC0DE_0004) begin fails++; $display("FAIL fetch_hold: got v=%0b d=%h want 0 c0de0004", bus.if_valid, bus.if_rdata); end
  endtask

  task automatic test_contention();
    @(negedge clk);
    bus.if_req = 1'b1; bus.if_addr = 32'h40;
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h100;
    #1;
    asserts++; if (bus.mem_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin fails++; $display("FAIL cont_gnt: got mem=%0b if=%0b want 1 0", bus.mem_gnt, bus.if_gnt); end
    asserts++; if (bus.stall_if !== 1'b1 || bus.ram_addr !== 30'h40) begin fails++; $display("FAIL cont_stall: got stall=%0b addr=%h want 1 40", bus.stall_if, bus.ram_addr); end
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b1 || bus.mem_rdata !== 32'hC0DE_0040) begin fails++; $display("FAIL cont_mem_resp: got v=%0b d=%h want 1 c0de0040", bus.mem_valid, bus.mem_rdata); end
    @(negedge clk);
    bus.mem_req = 1'b0;
    #1;
    asserts++; if (bus.if_gnt !== 1'b1 || bus.ram_addr !== 30'h10 || bus.stall_if !== 1'b0) begin fails++; $display("FAIL cont_if_gnt: got gnt=%0b addr=%h stall=%0b want 1 10 0", bus.if_gnt, bus.ram_addr, bus.stall_if); end
    @(posedge clk); #1;
    asserts++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hC0DE_0010 || bus.mem_valid !== 1'b0) begin fails++; $display("FAIL cont_if_resp: got v=%0b d=%h mv=%0b want 1 c0de0010 0", bus.if_valid, bus.if_rdata, bus.mem_valid); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_starvation();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'h80;
      bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h200 + 32'(4*k);
      #1;
      asserts++; if (bus.mem_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin fails++; $display("FAIL starve_mem_gnt%0d: got mem=%0b if=%0b want 1 0", k, bus.mem_gnt, bus.if_gnt); end
      @(posedge clk); #1;
      asserts++; if (bus.mem_valid !== 1'b1 || bus.mem_rdata !== 32'hC0DE_0080 + 32'(k)) begin fails++; $display("FAIL starve_mem_resp%0d: got v=%0b d=%h want 1 %h", k, bus.mem_valid, bus.mem_rdata, 32'hC0DE_0080 + 32'(k)); end
    end
    @(negedge clk);
    bus.mem_addr = 32'h210;
    #1;
    asserts++; if (bus.if_gnt !== 1'b1 || bus.mem_gnt !== 1'b0 || bus.ram_addr !== 30'h20) begin fails++; $display("FAIL starve_if_gnt: got if=%0b mem=%0b addr=%h want 1 0 20", bus.if_gnt, bus.mem_gnt, bus.ram_addr); end
    @(posedge clk); #1;
    asserts++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hC0DE_0020) begin fails++; $display("FAIL starve_if_resp: got v=%0b d=%h want 1 c0de0020", bus.if_valid, bus.if_rdata); end
    @(negedge clk);
    bus.mem_addr = 32'h300;
    #1;
    asserts++; if (bus.mem_gnt !== 1'b1 || bus.if_gnt !== 1'b0) begin fails++; $display("FAIL starve_cnt_clear: got mem=%0b if=%0b want 1 0", bus.mem_gnt, bus.if_gnt); end
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b1 || bus.mem_rdata !== 32'hC0DE_00C0) begin fails++; $display("FAIL starve_last_resp: got v=%0b d=%h want 1 c0de00c0", bus.mem_valid, bus.mem_rdata); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_store();
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_be = 4'b0011;
    bus.mem_addr = 32'h20; bus.mem_wdata = 32'hDEAD_BEEF;
    #1;
    asserts++; if (bus.mem_gnt !== 1'b1 || bus.ram_we !== 4'b0011) begin fails++; $display("FAIL store_we: got gnt=%0b we=%b want 1 0011", bus.mem_gnt, bus.ram_we); end
    asserts++; if (bus.ram_addr !== 30'h8 || bus.ram_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL store_addr: got addr=%h wd=%h want 8 deadbeef", bus.ram_addr, bus.ram_wdata); end
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b1 || bus.mem_rdata !== 32'hC0DE_00C0) begin fails++; $display("FAIL store_ack: got v=%0b d=%h want 1 c0de00c0", bus.mem_valid, bus.mem_rdata); end
    @(negedge clk);
    bus.mem_we = 1'b0; bus.mem_be = 4'b0000;
    #1;
    asserts++; if (bus.ram_we !== 4'b0000 || bus.ram_en !== 1'b1) begin fails++; $display("FAIL load_we: got we=%b en=%0b want 0000 1", bus.ram_we, bus.ram_en); end
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b1 || bus.mem_rdata !== 32'hC0DE_BEEF) begin fails++; $display("FAIL store_readback: got v=%0b d=%h want 1 c0debeef", bus.mem_valid, bus.mem_rdata); end
    @(negedge clk);
    idle();
  endtask

  task automatic test_back_to_back();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      bus.if_req = 1'b1; bus.if_addr = 32'(4*k);
      #1;
      asserts++; if (bus.if_gnt !== 1'b1 || bus.stall_if !== 1'b0) begin fails++; $display("FAIL b2b_gnt%0d: got gnt=%0b stall=%0b want 1 0", k, bus.if_gnt, bus.stall_if); end
      @(posedge clk); #1;
      asserts++; if (bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hC0DE_0000 + 32'(k)) begin fails++; $display("FAIL b2b_resp%0d: got v=%0b d=%h want 1 %h", k, bus.if_valid, bus.if_rdata, 32'hC0DE_0000 + 32'(k)); end
    end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    asserts++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL b2b_end: got v=%0b want 0", bus.if_valid); end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    bus.mem_req = 1'b1; bus.mem_we = 1'b0; bus.mem_addr = 32'h30;
    #1;
    asserts++; if (bus.mem_gnt !== 1'b1) begin fails++; $display("FAIL mid_gnt: got %0b want 1", bus.mem_gnt); end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    asserts++; if (bus.mem_valid !== 1'b0 || bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL mid_discard: got v=%0b d=%h want 0 0", bus.mem_valid, bus.mem_rdata); end
    asserts++; if (bus.mem_gnt !== 1'b0 || bus.ram_en !== 1'b0) begin fails++; $display("FAIL mid_gnt_rst: got gnt=%0b en=%0b want 0 0", bus.mem_gnt, bus.ram_en); end
    @(negedge clk);
    idle();
    rst = 1'b0;
    bus.if_req = 1'b1; bus.if_addr = 32'h0;
    #1;
    asserts++; if (bus.if_gnt !== 1'b1) begin fails++; $display("FAIL mid_first_gnt: got %0b want 1", bus.if_gnt); end
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b0 || bus.if_valid !== 1'b1 || bus.if_rdata !== 32'hC0DE_0000) begin fails++; $display("FAIL mid_after: got mv=%0b iv=%0b d=%h want 0 1 c0de0000", bus.mem_valid, bus.if_valid, bus.if_rdata); end
    @(negedge clk);
    idle();
    @(posedge clk); #1;
    asserts++; if (bus.mem_valid !== 1'b0 || bus.if_valid !== 1'b0 || bus.mem_rdata !== 32'h0) begin fails++; $display("FAIL mid_quiet: got mv=%0b iv=%0b md=%h want 0 0 0", bus.mem_valid, bus.if_valid, bus.mem_rdata); end
  endtask

  initial begin
    bus.ram_rdata = '0;
    idle();
    test_reset();
    test_single_fetch();
    test_contention();
    test_starvation();
    test_store();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end
endmodule

// File: doc/unified_mem_arbiter.md
# unified_mem_arbiter

Arbitrates one single-port, synchronous-read unified RAM between the instruction-fetch (IF) stage and the data-memory (MEM) stage of the pipelined RV32I core. It routes each RAM read response back to the requester that issued it, so it is the demultiplexing counterpart of the pipeline's select muxes. It also generates the fetch stall when the data port wins the RAM. The block sits between the IF/MEM stages and the RAM macro.

## Interface
- AW, 32: byte-address width of both requester ports.
- DW, 32: data width; fixed at 32 for RV32I.
- MAX_DATA_BURST, 4: maximum consecutive cycles the MEM port may win while IF is requesting; range 1–7.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level.
- if_addr  in  AW  fetch byte address.
- if_gnt  out  1  fetch address accepted this cycle (combinational).
- if_valid  out  1  fetch data valid (one-cycle pulse).
- if_rdata  out  DW  fetch data, registered, held between pulses.
- mem_req  in  1  load/store request, level.
- mem_we  in  1  1 = store, 0 = load.
- mem_be  in  4  store byte enables.
- mem_addr  in  AW  data byte address.
- mem_wdata  in  DW  store data.
- mem_gnt  out  1  data address accepted this cycle (combinational).
- mem_valid  out  1  load data valid or store acknowledge (one-cycle pulse).
- mem_rdata  out  DW  load data, registered, held between pulses.
- ram_en  out  1  RAM access this cycle.
- ram_we  out  4  RAM byte write enables.
- ram_addr  out  AW-2  RAM word index = granted addr[AW-1:2].
- ram_wdata  out  DW  RAM write data = mem_wdata.
- ram_rdata  in  DW  RAM read data, valid the cycle after ram_en with ram_we = 0.
- stall_if  out  1  if_req & ~if_gnt.

## Operation
- At most one RAM access per cycle. The grant is combinational from the current requests, `wait_cnt`, and `rst`.
- Default priority: MEM over IF.
- Starvation guard: the 3-bit `wait_cnt` counts consecutive cycles in which if_req = 1 and mem_gnt = 1.
  - When `wait_cnt` = MAX_DATA_BURST, IF wins that cycle.
  - `wait_cnt` clears on any if_gnt or whenever if_req = 0.
- On a grant:
  - ram_en = 1 and ram_addr = the granted address word.
  - ram_we = mem_be when MEM is granted with mem_we = 1; otherwise 0.
  - addr[1:0] are ignored.
- Owner register `owner` ∈ {NONE, IF, MEM_RD, MEM_WR} records the grant on each edge. NONE is recorded when nothing is granted.
- Response cycle, driven from `owner`:
  - IF: if_valid = 1 and if_rdata captures ram_rdata.
  - MEM_RD: mem_valid = 1 and mem_rdata captures ram_rdata.
  - MEM_WR: mem_valid = 1 and mem_rdata is unchanged.
  - NONE: no pulse.
- Requesters may present a new address in the cycle after their grant. Back-to-back grants to the same port are allowed, giving full throughput.
- Reset values:
  - owner = NONE, wait_cnt = 0.
  - if_valid = mem_valid = 0.
  - if_rdata = mem_rdata = 0.
  - While rst = 1, if_gnt = mem_gnt = ram_en = 0 and ram_we = 0.

## Timing
- Grant in cycle N → valid pulse in cycle N+1. Read data appears on if_rdata/mem_rdata in N+1 as a registered capture of ram_rdata. Fixed latency of 1.
- Simultaneous if_req and mem_req with wait_cnt < MAX_DATA_BURST: mem_gnt = 1, if_gnt = 0, stall_if = 1, wait_cnt increments.
- A request in the same cycle as that port's valid pulse is a new request and is arbitrated normally.
- Reset asserted mid-operation: the pending response is discarded and no valid pulse follows the release of reset. The first grant is possible in the first cycle with rst = 0.
- A store granted while the IF port is starved still writes the RAM. No read data is produced for the store.

## Test plan
- Reset: hold rst, drive both requests → all gnt/valid/ram_en = 0. After release, a single if_req to 0x0000_0010 → ram_addr = 0x4, if_valid next cycle with the RAM word.
- Contention: if_req and mem_req (load, 0x100) in the same cycle → mem_gnt = 1, stall_if = 1. Next cycle if_gnt = 1. mem_valid and if_valid pulse on consecutive cycles with correct data.
- Starvation: MEM requests every cycle with if_req held, MAX_DATA_BURST = 4 → 4 MEM grants, then if_gnt on the 5th cycle, wait_cnt returns to 0.
- Store: mem_we = 1, mem_be = 4'b0011, addr 0x20, wdata 0xDEADBEEF → ram_we = 0011, ram_addr = 0x8. mem_valid pulses next cycle and mem_rdata is unchanged. A subsequent load of 0x20 returns the RAM contents.
- Back-to-back fetches to 0x0, 0x4, 0x8 on consecutive cycles → three consecutive if_valid pulses in order, stall_if = 0 throughout.
- Reset mid-response: grant a load, assert rst the next cycle → mem_valid = 0 and mem_rdata = 0, and no pulse appears after rst falls.
